// File: rtl/hazard_forward_unit_pkg.sv
// Shared encodings for the EX operand selects and the hazard-unit pipeline-control FSM.
package hazard_forward_unit_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_EXM = 2'b10;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        BUBBLE = 2'b01,
        FREEZE = 2'b10
    } hazState_e;

endpackage

// File: rtl/hazard_forward_unit_src_hazard_cmp.sv
// Per-source comparator: picks the forwarding path for one ID operand and flags a load-use conflict.
module src_hazard_cmp
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  rsUsed,
    input  logic [REG_ADDR_W-1:0] exRd,
    input  logic                  exRegwrite,
    input  logic                  exMemread,
    input  logic [REG_ADDR_W-1:0] memRd,
    input  logic                  memRegwrite,
    output logic [1:0]            fwdNext,
    output logic                  lu
);

    logic exHit;
    logic memHit;

    // Register 0 is hardwired, so a zero destination never matches.
    assign exHit  = rsUsed && exRegwrite  && (exRd  != '0) && (exRd  == rs);
    assign memHit = rsUsed && memRegwrite && (memRd != '0) && (memRd == rs);

    always_comb begin
        fwdNext = FWD_RF;
        if (exHit) begin
            fwdNext = FWD_EXM;
        end else if (memHit) begin
            fwdNext = FWD_WB;
        end
    end

    assign lu = exHit && exMemread;

endmodule

// File: rtl/hazard_forward_unit.sv
// Data-hazard resolution beside ID/EX: registered operand selects, load-use stall, memory-wait freeze.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
    input  logic [NUM_SRC-1:0]            id_rs_used,
    input  logic [REG_ADDR_W-1:0]         ex_rd,
    input  logic [REG_ADDR_W-1:0]         mem_rd,
    input  logic                          ex_regwrite,
    input  logic                          mem_regwrite,
    input  logic                          ex_memread,
    input  logic                          flush,
    input  logic                          mem_wait,
    output logic [2*NUM_SRC-1:0]          fwd_sel,
    output logic                          stall_if_id,
    output logic                          bubble_ex,
    output logic                          freeze,
    output logic [CNT_W-1:0]              lu_stall_cnt,
    output logic [CNT_W-1:0]              freeze_cnt
);

    logic [2*NUM_SRC-1:0] fwdNext;
    logic [NUM_SRC-1:0]   luSrc;
    logic                 lu;
    hazState_e            state;
    hazState_e            stateNext;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != '1)) begin
            return v + CNT_W'(1);
        end
        return v;
    endfunction

    for (genvar i = 0; i < NUM_SRC; i++) begin : gSrc
        src_hazard_cmp #(
            .REG_ADDR_W(REG_ADDR_W)
        ) uCmp (
            .rs         (id_rs[i*REG_ADDR_W +: REG_ADDR_W]),
            .rsUsed     (id_rs_used[i]),
            .exRd       (ex_rd),
            .exRegwrite (ex_regwrite),
            .exMemread  (ex_memread),
            .memRd      (mem_rd),
            .memRegwrite(mem_regwrite),
            .fwdNext    (fwdNext[2*i +: 2]),
            .lu         (luSrc[i])
        );
    end

    assign lu = |luSrc;

    // A memory wait overrides everything; a flush kills the stalled instruction anyway.
    assign freeze      = mem_wait;
    assign stall_if_id = lu && !flush && !mem_wait;
    assign bubble_ex   = (lu || flush) && !mem_wait;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            RUN, BUBBLE: begin
                if (mem_wait) begin
                    stateNext = FREEZE;
                end else if (lu && !flush) begin
                    stateNext = BUBBLE;
                end else begin
                    stateNext = RUN;
                end
            end
            FREEZE: begin
                if (!mem_wait) begin
                    stateNext = RUN;
                end
            end
            default: stateNext = RUN;
        endcase
    end

    // ID -> EX boundary: selects computed in ID become valid for the whole EX cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_sel <= '0;
        end else if (!mem_wait) begin
            fwd_sel <= bubble_ex ? {NUM_SRC{FWD_RF}} : fwdNext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lu_stall_cnt <= '0;
            freeze_cnt   <= '0;
        end else begin
            lu_stall_cnt <= satInc(lu_stall_cnt, stall_if_id);
            freeze_cnt   <= satInc(freeze_cnt, mem_wait);
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed plus randomized bench for hazard_forward_unit against a rule-level reference model.
module tb_hazard_forward_unit;

    localparam int RW      = 5;
    localparam int NS      = 2;
    localparam int CW      = 5;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS*RW-1:0]  id_rs;
    logic [NS-1:0]     id_rs_used;
    logic [RW-1:0]     ex_rd;
    logic [RW-1:0]     mem_rd;
    logic              ex_regwrite;
    logic              mem_regwrite;
    logic              ex_memread;
    logic              flush;
    logic              mem_wait;
    logic [2*NS-1:0]   fwd_sel;
    logic              stall_if_id;
    logic              bubble_ex;
    logic              freeze;
    logic [CW-1:0]     lu_stall_cnt;
    logic [CW-1:0]     freeze_cnt;

    int checks   = 0;
    int failures = 0;

    // Stimulus for the current step and the model's architectural view.
    int  rsA[NS];
    bit  usedA[NS];
    int  exRdV, memRdV;
    bit  exWrV, memWrV, exLdV, flushV, waitV;
    logic [2*NS-1:0] expFwd;
    int  expLuCnt, expFrzCnt;

    always #5 clk = ~clk;

    hazard_forward_unit #(
        .REG_ADDR_W(RW),
        .NUM_SRC   (NS),
        .CNT_W     (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs       (id_rs),
        .id_rs_used  (id_rs_used),
        .ex_rd       (ex_rd),
        .mem_rd      (mem_rd),
        .ex_regwrite (ex_regwrite),
        .mem_regwrite(mem_regwrite),
        .ex_memread  (ex_memread),
        .flush       (flush),
        .mem_wait    (mem_wait),
        .fwd_sel     (fwd_sel),
        .stall_if_id (stall_if_id),
        .bubble_ex   (bubble_ex),
        .freeze      (freeze),
        .lu_stall_cnt(lu_stall_cnt),
        .freeze_cnt  (freeze_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit hits(input int rd, input bit wr, input int r);
        return wr && (rd != 0) && (rd == r);
    endfunction

    task automatic resetModel();
        expFwd    = '0;
        expLuCnt  = 0;
        expFrzCnt = 0;
    endtask

    task automatic setIn(input int r0, input int r1, input bit u0, input bit u1,
                         input int er, input bit ew, input bit el,
                         input int mr, input bit mw, input bit fl, input bit wt);
        rsA[0] = r0; rsA[1] = r1; usedA[0] = u0; usedA[1] = u1;
        exRdV = er; exWrV = ew; exLdV = el;
        memRdV = mr; memWrV = mw; flushV = fl; waitV = wt;
    endtask

    // Drive one cycle, check the combinational controls, then the state after the edge.
    task automatic step(input string tag);
        logic [2*NS-1:0] nxt;
        bit lu, expStall, expBubble;
        nxt = '0;
        lu  = 1'b0;
        for (int i = 0; i < NS; i++) begin
            id_rs[i*RW +: RW] = RW'(rsA[i]);
            id_rs_used[i]     = usedA[i];
            if (usedA[i] && hits(exRdV, exWrV, rsA[i])) begin
                nxt[2*i +: 2] = 2'b10;
                if (exLdV) lu = 1'b1;
            end else if (usedA[i] && hits(memRdV, memWrV, rsA[i])) begin
                nxt[2*i +: 2] = 2'b01;
            end
        end
        ex_rd        = RW'(exRdV);
        ex_regwrite  = exWrV;
        ex_memread   = exLdV;
        mem_rd       = RW'(memRdV);
        mem_regwrite = memWrV;
        flush        = flushV;
        mem_wait     = waitV;
        #1;
        expStall  = lu && !flushV && !waitV;
        expBubble = (lu || flushV) && !waitV;
        chk({tag, "/stall"},  32'(stall_if_id), 32'(expStall));
        chk({tag, "/bubble"}, 32'(bubble_ex),   32'(expBubble));
        chk({tag, "/freeze"}, 32'(freeze),      32'(waitV));
        if (!waitV) expFwd = expBubble ? '0 : nxt;
        if (expStall && expLuCnt < CNT_MAX) expLuCnt++;
        if (waitV && expFrzCnt < CNT_MAX) expFrzCnt++;
        @(posedge clk);
        #1;
        chk({tag, "/fwd"},    32'(fwd_sel),      32'(expFwd));
        chk({tag, "/lucnt"},  32'(lu_stall_cnt), expLuCnt);
        chk({tag, "/frzcnt"}, 32'(freeze_cnt),   expFrzCnt);
    endtask

    task automatic asyncReset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        chk({tag, "/fwd"},    32'(fwd_sel),      32'd0);
        chk({tag, "/lucnt"},  32'(lu_stall_cnt), 32'd0);
        chk({tag, "/frzcnt"}, 32'(freeze_cnt),   32'd0);
        resetModel();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        resetModel();
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        id_rs = '0; id_rs_used = '0; ex_rd = '0; mem_rd = '0;
        ex_regwrite = 1'b0; mem_regwrite = 1'b0; ex_memread = 1'b0;
        flush = 1'b0; mem_wait = 1'b0;
        #12;
        chk("reset/fwd",    32'(fwd_sel),      32'd0);
        chk("reset/lucnt",  32'(lu_stall_cnt), 32'd0);
        chk("reset/frzcnt", 32'(freeze_cnt),   32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Back-to-back ALU ops
        setIn(5, 5, 1, 1, 5, 1, 0, 0, 0, 0, 0);
        step("alu");
        chk("alu/const", 32'(fwd_sel), 32'b1010);

        // EX/MEM priority over MEM/WB, then MEM/WB alone
        setIn(7, 0, 1, 0, 7, 1, 0, 7, 1, 0, 0);
        step("prio");
        chk("prio/const", 32'(fwd_sel[1:0]), 32'b10);
        setIn(7, 0, 1, 0, 8, 1, 0, 7, 1, 0, 0);
        step("wbonly");
        chk("wbonly/const", 32'(fwd_sel[1:0]), 32'b01);

        // Load-use: one bubble, then the load is in MEM
        setIn(0, 3, 0, 1, 3, 1, 1, 0, 0, 0, 0);
        step("lu");
        setIn(0, 3, 0, 1, 0, 0, 0, 3, 1, 0, 0);
        step("lu_after");
        chk("lu_after/const", 32'(fwd_sel[3:2]), 32'b01);
        chk("lu_cnt/const",   32'(lu_stall_cnt), 32'd1);

        // Load-use with a simultaneous flush
        setIn(0, 3, 0, 1, 3, 1, 1, 0, 0, 1, 0);
        step("lu_flush");

        // mem_wait for 4 cycles over a pending load-use, with a nonzero select to hold
        setIn(5, 5, 1, 1, 5, 1, 0, 0, 0, 0, 0);
        step("pre_wait");
        for (int k = 0; k < 4; k++) begin
            setIn(0, 3, 0, 1, 3, 1, 1, 0, 0, 0, 1);
            step("wait");
        end
        chk("wait/fwd_hold", 32'(fwd_sel),    32'b1010);
        chk("wait/frz4",     32'(freeze_cnt), 32'd4);
        setIn(0, 3, 0, 1, 3, 1, 1, 0, 0, 0, 0);
        step("wait_release");
        setIn(0, 3, 0, 1, 0, 0, 0, 3, 1, 0, 0);
        step("wait_after");

        // Zero destination never forwards or stalls
        setIn(0, 0, 1, 1, 0, 1, 1, 0, 1, 0, 0);
        step("rd0");

        // Asynchronous reset while in BUBBLE
        setIn(5, 0, 1, 0, 5, 1, 0, 0, 0, 0, 0);
        step("pre_bubble");
        setIn(5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0);
        step("bubble");
        asyncReset("arst_bubble");

        // Randomized traffic; counters saturate at the narrow width
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NS; i++) begin
                rsA[i]   = int'($urandom_range(0, 7));
                usedA[i] = ($urandom_range(0, 3) != 0);
            end
            exRdV  = int'($urandom_range(0, 7));
            exWrV  = ($urandom_range(0, 3) != 0);
            exLdV  = ($urandom_range(0, 1) != 0);
            memRdV = int'($urandom_range(0, 7));
            memWrV = ($urandom_range(0, 3) != 0);
            flushV = ($urandom_range(0, 9) == 0);
            waitV  = ($urandom_range(0, 3) == 0);
            step("rand");
        end
        chk("rand/frz_sat", 32'(freeze_cnt), CNT_MAX);
        asyncReset("arst_rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
